// File: rtl/arb_defs.sv
// Shared definitions for the packet-aware 2:1 arbiter/mux.
// State codes, channel indices and the arbitration pick rule live here.
package arb_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // A lone requester wins outright; on contention the priority pointer decides.
    function automatic logic pick_channel(
        input logic v0,
        input logic v1,
        input logic pri
    );
        logic pick;
        if (v0 && v1) begin
            pick = pri;
        end else if (v1) begin
            pick = CH1;
        end else begin
            pick = CH0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_2_1_w.sv
// WIDTH-bit 2:1 select: Y = S ? I[2*WIDTH-1:WIDTH] : I[WIDTH-1:0].
// Built bit by bit so it maps onto plain LUT muxes with no arithmetic.
module mux_2_1_w
    import arb_defs::*;
#(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0]   Y,
    input  logic [2*WIDTH-1:0] I,
    input  logic               S
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign Y[gi] = (S == CH1) ? I[WIDTH+gi] : I[gi];
        end
    endgenerate

endmodule

// File: rtl/arb_mux_2_1.sv
// Packet-aware round-robin arbiter driving a 2:1 mux into a registered output stage.
// A grant is held from the first beat until the beat flagged last, then priority rotates.
module arb_mux_2_1
    import arb_defs::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_valid,
    input  logic             in0_last,
    output logic             in0_ready,

    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_valid,
    input  logic             in1_last,
    output logic             in1_ready,

    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,

    output logic             sel
);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             pri_q, pri_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic [WIDTH-1:0] mux_data;
    logic             mux_last;
    logic             mux_valid;
    logic             out_room;
    logic             granted;
    logic             accept;

    mux_2_1_w #(.WIDTH(WIDTH)) u_data_mux (
        .Y (mux_data),
        .I ({in1_data, in0_data}),
        .S (sel_q)
    );

    mux_2_1_w #(.WIDTH(1)) u_last_mux (
        .Y (mux_last),
        .I ({in1_last, in0_last}),
        .S (sel_q)
    );

    // The output register can take a beat when empty or draining this same edge.
    assign out_room  = !out_valid_q || out_ready;
    assign mux_valid = (sel_q == CH1) ? in1_valid : in0_valid;
    assign granted   = (state_q == ST_GRANT);
    assign accept    = granted && mux_valid && out_room;

    assign in0_ready = granted && (sel_q == CH0) && out_room;
    assign in1_ready = granted && (sel_q == CH1) && out_room;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        pri_d       = pri_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in0_valid || in1_valid) begin
                    sel_d   = pick_channel(in0_valid, in1_valid, pri_q);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A stalled granted channel keeps the grant indefinitely.
                if (accept) begin
                    out_data_d  = mux_data;
                    out_last_d  = mux_last;
                    out_valid_d = 1'b1;
                    if (mux_last) begin
                        state_d = ST_IDLE;
                        pri_d   = ~sel_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= CH0;
            pri_q       <= CH0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            pri_q       <= pri_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;

endmodule
